// File: rtl/arith_pkg.sv
// arith_pkg: shared FSM state type and default width for the serial arithmetic blocks
//   (no ports; exports sub_state_t and DEFAULT_WIDTH)
package arith_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_t;
    localparam int DEFAULT_WIDTH = 4;
endpackage

// File: rtl/full_sub.sv
// full_sub: one-bit full subtractor cell computing a - b - bin
//   in  a, b, bin : minuend bit, subtrahend bit, borrow-in
//   out d, bout   : difference bit, borrow-out
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, one bit per clock LSB first, start/done handshake
//   in  clk, rst_n (sync, active-low), start, a[WIDTH], b[WIDTH], bin
//   out busy (bits in flight), done (1-cycle result pulse), diff[WIDTH], bout
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    localparam int CW = $clog2(WIDTH + 1);

    sub_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d, bout_q, bout_d;
    logic             d_bit, br_next;

    full_sub u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .d    (d_bit),
        .bout (br_next)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SHIFT;
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    diff_d  = '0;
                    bout_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                br_d   = br_next;
                cnt_d  = cnt_q + CW'(1);
                // new bit enters at the MSB so bit i settles at diff[i] after WIDTH shifts
                diff_d = (diff_q >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    bout_d  = br_next;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of serial_subtractor at WIDTH=4
module tb_serial_subtractor;
    logic       clk = 1'b0;
    logic       rst_n, start, bin;
    logic [3:0] a, b;
    logic       busy, done, bout;
    logic [3:0] diff;
    int         n_cmp = 0;
    int         n_fail = 0;

    serial_subtractor #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    // Issue one operation and wait for done; cyc counts edges from the accepting edge.
    task automatic do_op(input logic [3:0] ia, input logic [3:0] ib, input logic ibin, output int cyc);
        a = ia; b = ib; bin = ibin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = ~ia; b = ~ib; bin = ~ibin;
        cyc = 1;
        while (done !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL op_timeout: done=%b after %0d edges, required 1", done, cyc);
        end
    endtask

    task automatic test_reset;
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_busy_done: got %b required 00", {busy, done});
        end
        n_cmp++;
        if ({bout, diff} !== 5'h00) begin
            n_fail++;
            $display("FAIL reset_result: got %h required 00", {bout, diff});
        end
    endtask

    task automatic test_basic;
        a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            n_cmp++;
            if ({busy, done} !== 2'b10) begin
                n_fail++;
                $display("FAIL basic_busy_%0d: busy,done=%b required 10", k, {busy, done});
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if ({busy, done} !== 2'b01) begin
            n_fail++;
            $display("FAIL basic_done: busy,done=%b required 01", {busy, done});
        end
        n_cmp++;
        if ({bout, diff} !== 5'h06) begin
            n_fail++;
            $display("FAIL basic_result: bout,diff=%h required 06", {bout, diff});
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({done, bout, diff} !== 6'h06) begin
            n_fail++;
            $display("FAIL basic_pulse_hold: done,bout,diff=%h required 06", {done, bout, diff});
        end
    endtask

    task automatic test_vectors;
        logic [3:0] va [4] = '{4'd3, 4'd0, 4'd15, 4'd15};
        logic [3:0] vb [4] = '{4'd9, 4'd0, 4'd15, 4'd0};
        logic       vc [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [4:0] ve [4] = '{5'h1A, 5'h1F, 5'h1F, 5'h0F};
        int cyc;
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], vc[i], cyc);
            n_cmp++;
            if ({bout, diff} !== ve[i] || cyc != 5) begin
                n_fail++;
                $display("FAIL vector_%0d: bout,diff=%h cyc=%0d required %h cyc=5", i, {bout, diff}, cyc, ve[i]);
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int cyc;
        a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = 4'd1; b = 4'd1;
        cyc = 1;
        while (done !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_cmp++;
        if ({bout, diff} !== 5'h06 || cyc != 5) begin
            n_fail++;
            $display("FAIL ignore_start: bout,diff=%h cyc=%0d required 06 cyc=5", {bout, diff}, cyc);
        end
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++;
        if ({busy, done} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_accept: busy,done=%b required 10", {busy, done});
        end
        cyc = 6;
        while (done !== 1'b1 && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_cmp++;
        if ({bout, diff} !== 5'h00 || cyc != 10) begin
            n_fail++;
            $display("FAIL b2b_second: bout,diff=%h edge=%0d required 00 edge=10", {bout, diff}, cyc);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort;
        int cyc;
        a = 4'd9; b = 4'd2; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_cmp++;
        if ({busy, done, bout, diff} !== 7'h00) begin
            n_fail++;
            $display("FAIL abort_outputs: busy,done,bout,diff=%h required 00", {busy, done, bout, diff});
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL abort_idle: busy,done=%b required 00", {busy, done});
        end
        do_op(4'd7, 4'd2, 1'b0, cyc);
        n_cmp++;
        if ({bout, diff} !== 5'h05 || cyc != 5) begin
            n_fail++;
            $display("FAIL abort_restart: bout,diff=%h cyc=%0d required 05 cyc=5", {bout, diff}, cyc);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        logic [3:0] ra, rb;
        logic       rc;
        logic [4:0] exp;
        int cyc;
        for (int i = 0; i < 1000; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rc = 1'($urandom_range(0, 1));
            exp = {1'b0, ra} - {1'b0, rb} - {4'b0, rc};
            do_op(ra, rb, rc, cyc);
            n_cmp++;
            if ({bout, diff} !== exp || cyc != 5) begin
                n_fail++;
                $display("FAIL random_%0d: %h-%h-%b gave %h cyc=%0d required %h cyc=5", i, ra, rb, rc, {bout, diff}, cyc, exp);
            end
            if (i % 2 == 0) begin
                for (int k = 0; k < 2; k++) begin
                    @(posedge clk); #1;
                    n_cmp++;
                    if ({done, bout, diff} !== {1'b0, exp}) begin
                        n_fail++;
                        $display("FAIL random_hold_%0d: done,bout,diff=%h required %h", i, {done, bout, diff}, {1'b0, exp});
                    end
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        test_reset;
        test_basic;
        test_vectors;
        test_back_to_back;
        test_reset_abort;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
